// File: rtl/ecc_pkg.sv
// Shared constants and FSM state type for the ECC nibble I/O front-end.
package ecc_pkg;

  localparam int unsigned SIZE    = 32;
  localparam int unsigned NIB     = 4;
  localparam int unsigned NUM_NIB = SIZE / NIB;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    ANNOUNCE,
    SHIFT
  } state_t;

endpackage

// File: rtl/nibble_shreg.sv
// SIZE-bit register that can be cleared, written one nibble at a given
// index, loaded in parallel, or shifted right by one nibble (LSB nibble out).
module nibble_shreg #(
  parameter int unsigned SIZE = ecc_pkg::SIZE,
  parameter int unsigned NIB  = ecc_pkg::NIB,
  localparam int unsigned IDX_W = $clog2(SIZE / NIB)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [NIB-1:0]   i_nib,
  input  logic             i_load,
  input  logic [SIZE-1:0]  i_par,
  input  logic             i_shift,
  output logic [SIZE-1:0]  o_data
);

  logic [SIZE-1:0] r_data;

  // Storage update; clear wins over parallel load, which wins over nibble write and shift.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
    end else if (i_clr) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_par;
    end else if (i_wr) begin
      r_data[i_idx*NIB +: NIB] <= i_nib;
    end else if (i_shift) begin
      r_data <= r_data >> NIB;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/ecc_nibble_io.sv
// Pin-level front-end: deserializes five LSB-first nibble streams into
// 32-bit operands, launches the core, then announces and streams the result.
module ecc_nibble_io #(
  parameter int unsigned SIZE = ecc_pkg::SIZE,
  parameter int unsigned NIB  = ecc_pkg::NIB
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [NIB-1:0]  a,
  input  logic [NIB-1:0]  prime,
  input  logic [NIB-1:0]  k,
  input  logic [NIB-1:0]  Px,
  input  logic [NIB-1:0]  Py,
  output logic            o_core_start,
  output logic [SIZE-1:0] o_a,
  output logic [SIZE-1:0] o_prime,
  output logic [SIZE-1:0] o_k,
  output logic [SIZE-1:0] o_px,
  output logic [SIZE-1:0] o_py,
  input  logic            i_core_done,
  input  logic [SIZE-1:0] i_kpx,
  input  logic [SIZE-1:0] i_kpy,
  output logic [NIB-1:0]  kPx,
  output logic [NIB-1:0]  kPy,
  output logic            done
);
  import ecc_pkg::*;

  localparam int unsigned      CNT_W    = $clog2(SIZE / NIB);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(SIZE / NIB - 1);

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             r_core_start, w_core_start_nx;
  logic             w_clr, w_wr, w_cap, w_shift;
  logic [SIZE-1:0]  w_rx, w_ry;

  // State, nibble counter and the registered core launch pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_core_start <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_core_start <= w_core_start_nx;
    end
  end

  // Next-state logic and register strobes for the load/run/announce/shift sequence.
  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_core_start_nx = 1'b0;
    w_clr           = 1'b0;
    w_wr            = 1'b0;
    w_cap           = 1'b0;
    w_shift         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nx = LOAD;
          w_cnt_nx   = '0;
        end
      end
      LOAD: begin
        // A start inside LOAD restarts capture; that cycle's pins are discarded.
        if (i_start) begin
          w_clr    = 1'b1;
          w_cnt_nx = '0;
        end else begin
          w_wr = 1'b1;
          if (r_cnt == LAST_NIB) begin
            w_cnt_nx        = '0;
            w_core_start_nx = 1'b1;
            w_state_nx      = RUN;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      RUN: begin
        if (i_core_done) begin
          w_cap      = 1'b1;
          w_state_nx = ANNOUNCE;
        end
      end
      ANNOUNCE: begin
        w_state_nx = SHIFT;
        w_cnt_nx   = '0;
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == LAST_NIB) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  nibble_shreg #(.SIZE(SIZE), .NIB(NIB)) u_des_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(w_clr), .i_wr(w_wr), .i_idx(r_cnt),
    .i_nib(a), .i_load(1'b0), .i_par('0), .i_shift(1'b0), .o_data(o_a)
  );

  nibble_shreg #(.SIZE(SIZE), .NIB(NIB)) u_des_prime (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(w_clr), .i_wr(w_wr), .i_idx(r_cnt),
    .i_nib(prime), .i_load(1'b0), .i_par('0), .i_shift(1'b0), .o_data(o_prime)
  );

  nibble_shreg #(.SIZE(SIZE), .NIB(NIB)) u_des_k (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(w_clr), .i_wr(w_wr), .i_idx(r_cnt),
    .i_nib(k), .i_load(1'b0), .i_par('0), .i_shift(1'b0), .o_data(o_k)
  );

  nibble_shreg #(.SIZE(SIZE), .NIB(NIB)) u_des_px (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(w_clr), .i_wr(w_wr), .i_idx(r_cnt),
    .i_nib(Px), .i_load(1'b0), .i_par('0), .i_shift(1'b0), .o_data(o_px)
  );

  nibble_shreg #(.SIZE(SIZE), .NIB(NIB)) u_des_py (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(w_clr), .i_wr(w_wr), .i_idx(r_cnt),
    .i_nib(Py), .i_load(1'b0), .i_par('0), .i_shift(1'b0), .o_data(o_py)
  );

  nibble_shreg #(.SIZE(SIZE), .NIB(NIB)) u_ser_kpx (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(1'b0), .i_wr(1'b0), .i_idx('0),
    .i_nib('0), .i_load(w_cap), .i_par(i_kpx), .i_shift(w_shift), .o_data(w_rx)
  );

  nibble_shreg #(.SIZE(SIZE), .NIB(NIB)) u_ser_kpy (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(1'b0), .i_wr(1'b0), .i_idx('0),
    .i_nib('0), .i_load(w_cap), .i_par(i_kpy), .i_shift(w_shift), .o_data(w_ry)
  );

  assign o_core_start = r_core_start;
  assign done         = (r_state == ANNOUNCE);
  assign kPx          = (r_state == SHIFT) ? w_rx[NIB-1:0] : '0;
  assign kPy          = (r_state == SHIFT) ? w_ry[NIB-1:0] : '0;

endmodule

// File: tb/tb_ecc_nibble_io.sv
// Directed bench for ecc_nibble_io: operand load, result stream, restart,
// ignored events, reset during streaming and back-to-back transactions.
module tb_ecc_nibble_io;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [3:0]  a = '0, prime = '0, k = '0, Px = '0, Py = '0;
  logic        o_core_start;
  logic [31:0] o_a, o_prime, o_k, o_px, o_py;
  logic        i_core_done = 1'b0;
  logic [31:0] i_kpx = '0, i_kpy = '0;
  logic [3:0]  kPx, kPy;
  logic        done;

  int total = 0;
  int bad   = 0;

  ecc_nibble_io #(.SIZE(32), .NIB(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .a(a), .prime(prime), .k(k), .Px(Px), .Py(Py),
    .o_core_start(o_core_start),
    .o_a(o_a), .o_prime(o_prime), .o_k(o_k), .o_px(o_px), .o_py(o_py),
    .i_core_done(i_core_done), .i_kpx(i_kpx), .i_kpy(i_kpy),
    .kPx(kPx), .kPy(kPy), .done(done)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Start strobe (optional) then 8 nibble cycles; returns in cycle S+9.
  task automatic drive_load(input logic with_start,
                            input logic [31:0] va, vp, vk, vx, vy,
                            output int cs_early, output logic cs_at);
    cs_early = 0;
    if (with_start) begin
      i_start = 1'b1;
      step();
      i_start = 1'b0;
    end
    for (int n = 0; n < 8; n++) begin
      if (o_core_start) cs_early++;
      a = va[4*n +: 4]; prime = vp[4*n +: 4]; k = vk[4*n +: 4];
      Px = vx[4*n +: 4]; Py = vy[4*n +: 4];
      step();
    end
    a = '0; prime = '0; k = '0; Px = '0; Py = '0;
    cs_at = o_core_start;
  endtask

  // Waits, pulses core done, then records the announce cycle and 8 output nibbles.
  task automatic drive_result(input logic [31:0] kx, ky, input int delay, input logic start_last,
                              output logic ann_done, output logic ann_zero,
                              output logic [31:0] gx, output logic [31:0] gy,
                              output int extra_done, output logic after_zero);
    for (int d = 0; d < delay; d++) step();
    i_core_done = 1'b1; i_kpx = kx; i_kpy = ky;
    step();
    i_core_done = 1'b0; i_kpx = ~kx; i_kpy = ~ky;
    ann_done = done;
    ann_zero = (kPx == 4'h0) && (kPy == 4'h0);
    extra_done = 0; gx = '0; gy = '0;
    for (int n = 0; n < 8; n++) begin
      step();
      gx[4*n +: 4] = kPx;
      gy[4*n +: 4] = kPy;
      if (done) extra_done++;
      if (n == 7) i_start = start_last;
    end
    step();
    i_start = 1'b0;
    after_zero = (kPx == 4'h0) && (kPy == 4'h0) && !done;
  endtask

  // Counts launch pulses, done pulses and non-zero result pins over n cycles.
  task automatic watch(input int cycles, output int cs_cnt, output int done_cnt, output int kp_cnt);
    cs_cnt = 0; done_cnt = 0; kp_cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (o_core_start) cs_cnt++;
      if (done) done_cnt++;
      if (kPx != 4'h0 || kPy != 4'h0) kp_cnt++;
    end
  endtask

  task automatic test_reset();
    @(posedge i_clk); @(posedge i_clk); #1;
    total++; if ({o_a, o_prime, o_k, o_px, o_py} !== 160'h0) begin bad++; $display("FAIL reset_ops got=%h exp=0", {o_a, o_prime, o_k, o_px, o_py}); end
    total++; if ({o_core_start, done} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {o_core_start, done}); end
    total++; if ({kPx, kPy} !== 8'h00) begin bad++; $display("FAIL reset_pins got=%h exp=00", {kPx, kPy}); end
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_load_and_stream();
    int cs_early; logic cs_at;
    logic ad, az, aft; logic [31:0] gx, gy; int xd;
    drive_load(1'b1, 32'h1, 32'h17, 32'h5, 32'hA, 32'h0000_00B0, cs_early, cs_at);
    total++; if (o_a !== 32'h0000_0001) begin bad++; $display("FAIL basic_a got=%h exp=00000001", o_a); end
    total++; if (o_prime !== 32'h0000_0017) begin bad++; $display("FAIL basic_prime got=%h exp=00000017", o_prime); end
    total++; if (o_k !== 32'h0000_0005) begin bad++; $display("FAIL basic_k got=%h exp=00000005", o_k); end
    total++; if ({o_px, o_py} !== {32'hA, 32'hB0}) begin bad++; $display("FAIL basic_pxpy got=%h exp=%h", {o_px, o_py}, {32'hA, 32'hB0}); end
    total++; if (cs_early !== 0) begin bad++; $display("FAIL basic_cs_early got=%0d exp=0", cs_early); end
    total++; if (cs_at !== 1'b1) begin bad++; $display("FAIL basic_cs_s9 got=%b exp=1", cs_at); end
    step();
    total++; if (o_core_start !== 1'b0) begin bad++; $display("FAIL basic_cs_s10 got=%b exp=0", o_core_start); end
    drive_result(32'h89AB_CDEF, 32'h0123_4567, 3, 1'b0, ad, az, gx, gy, xd, aft);
    total++; if (ad !== 1'b1) begin bad++; $display("FAIL stream_done got=%b exp=1", ad); end
    total++; if (az !== 1'b1) begin bad++; $display("FAIL stream_ann_pins got=%b exp=1", az); end
    total++; if (gx !== 32'h89AB_CDEF) begin bad++; $display("FAIL stream_kpx got=%h exp=89abcdef", gx); end
    total++; if (gy !== 32'h0123_4567) begin bad++; $display("FAIL stream_kpy got=%h exp=01234567", gy); end
    total++; if (xd !== 0) begin bad++; $display("FAIL stream_done_width got=%0d exp=0", xd); end
    total++; if (aft !== 1'b1) begin bad++; $display("FAIL stream_after got=%b exp=1", aft); end
  endtask

  task automatic test_restart();
    int cs_pre, cs_early; logic cs_at;
    logic ad, az, aft; logic [31:0] gx, gy; int xd;
    cs_pre = 0;
    i_start = 1'b1; step(); i_start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      a = 4'hF; prime = 4'hF; k = 4'hF; Px = 4'hF; Py = 4'hF;
      step();
      if (o_core_start) cs_pre++;
    end
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    if (o_core_start) cs_pre++;
    total++; if ({o_a, o_prime, o_k, o_px, o_py} !== 160'h0) begin bad++; $display("FAIL restart_clear got=%h exp=0", {o_a, o_prime, o_k, o_px, o_py}); end
    drive_load(1'b0, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 32'h0, cs_early, cs_at);
    total++; if (o_px !== 32'h1234_5678) begin bad++; $display("FAIL restart_px got=%h exp=12345678", o_px); end
    total++; if (o_a !== 32'h0) begin bad++; $display("FAIL restart_a got=%h exp=00000000", o_a); end
    total++; if ({cs_pre + cs_early, cs_at} !== {32'd0, 1'b1}) begin bad++; $display("FAIL restart_cs got=%0d/%b exp=0/1", cs_pre + cs_early, cs_at); end
    step();
    total++; if (o_core_start !== 1'b0) begin bad++; $display("FAIL restart_single_cs got=%b exp=0", o_core_start); end
    drive_result(32'h0BAD_F00D, 32'h7777_0001, 1, 1'b0, ad, az, gx, gy, xd, aft);
    total++; if ({gx, gy} !== {32'h0BAD_F00D, 32'h7777_0001}) begin bad++; $display("FAIL restart_result got=%h exp=0badf00d77770001", {gx, gy}); end
  endtask

  task automatic test_ignored();
    int cs_early; logic cs_at; int cc, dc, kc;
    logic ad, az, aft; logic [31:0] gx, gy; int xd;
    drive_load(1'b1, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, cs_early, cs_at);
    step();
    i_start = 1'b1; step(); i_start = 1'b0;
    watch(12, cc, dc, kc);
    total++; if ({cc, dc} !== {32'd0, 32'd0}) begin bad++; $display("FAIL ign_start_run got=cs%0d/done%0d exp=0/0", cc, dc); end
    drive_result(32'hFEDC_BA98, 32'h7654_3210, 1, 1'b1, ad, az, gx, gy, xd, aft);
    total++; if ({ad, gx, gy} !== {1'b1, 32'hFEDC_BA98, 32'h7654_3210}) begin bad++; $display("FAIL ign_still_run got=%h exp=%h", {ad, gx, gy}, {1'b1, 32'hFEDC_BA98, 32'h7654_3210}); end
    watch(12, cc, dc, kc);
    total++; if (cc !== 0) begin bad++; $display("FAIL ign_start_last_shift got=%0d exp=0", cc); end
    i_core_done = 1'b1; i_kpx = 32'hFFFF_FFFF; i_kpy = 32'hFFFF_FFFF;
    step();
    i_core_done = 1'b0;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL ign_done_idle got=%b exp=0", done); end
    watch(12, cc, dc, kc);
    total++; if ({cc, dc, kc} !== {32'd0, 32'd0, 32'd0}) begin bad++; $display("FAIL ign_done_idle_quiet got=%0d/%0d/%0d exp=0/0/0", cc, dc, kc); end
  endtask

  task automatic test_reset_mid_shift();
    int cs_early; logic cs_at; int cc, dc, kc;
    logic ad, az, aft; logic [31:0] gx, gy; int xd;
    drive_load(1'b1, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004, 32'hEEEE_0005, cs_early, cs_at);
    step();
    i_core_done = 1'b1; i_kpx = 32'hA5C3_E1F7; i_kpy = 32'h1357_9BDF;
    step();
    i_core_done = 1'b0;
    for (int n = 0; n < 4; n++) step();
    total++; if ({kPx, kPy} !== 8'hE9) begin bad++; $display("FAIL rst_nib3 got=%h exp=e9", {kPx, kPy}); end
    #2 i_rst_n = 1'b0;
    #1;
    total++; if ({kPx, kPy, done, o_core_start} !== 10'h0) begin bad++; $display("FAIL rst_outputs got=%h exp=0", {kPx, kPy, done, o_core_start}); end
    total++; if ({o_a, o_prime, o_k, o_px, o_py} !== 160'h0) begin bad++; $display("FAIL rst_ops got=%h exp=0", {o_a, o_prime, o_k, o_px, o_py}); end
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    watch(12, cc, dc, kc);
    total++; if ({cc, dc, kc} !== {32'd0, 32'd0, 32'd0}) begin bad++; $display("FAIL rst_quiet got=%0d/%0d/%0d exp=0/0/0", cc, dc, kc); end
    drive_load(1'b1, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888, 32'h9999_AAAA, cs_early, cs_at);
    total++; if ({o_k, cs_early, cs_at} !== {32'h5555_6666, 32'd0, 1'b1}) begin bad++; $display("FAIL rst_reload got=%h/%0d/%b exp=55556666/0/1", o_k, cs_early, cs_at); end
    drive_result(32'h0F1E_2D3C, 32'h4B5A_6978, 2, 1'b0, ad, az, gx, gy, xd, aft);
    total++; if ({ad, gx, gy, aft} !== {1'b1, 32'h0F1E_2D3C, 32'h4B5A_6978, 1'b1}) begin bad++; $display("FAIL rst_rerun got=%h exp=%h", {ad, gx, gy, aft}, {1'b1, 32'h0F1E_2D3C, 32'h4B5A_6978, 1'b1}); end
  endtask

  task automatic test_back_to_back();
    int cs_early; logic cs_at; int cc, dc, kc;
    logic ad, az, aft; logic [31:0] gx, gy; int xd;
    logic [31:0] va, vp, vk, vx, vy, ex, ey;
    for (int i = 0; i < 10; i++) begin
      va = 32'h1357_0000 + 32'(i) * 32'h0011_2233;
      vp = 32'hFFFF_FFFB - 32'(i);
      vk = 32'h8000_0001 ^ (32'(i) << 7);
      vx = 32'h1234_5678 + 32'(i) * 32'h0F0F_0F0F;
      vy = ~vx ^ 32'(i);
      ex = va * vk + vx;
      ey = vp ^ vy ^ {vx[15:0], vx[31:16]};
      drive_load(1'b1, va, vp, vk, vx, vy, cs_early, cs_at);
      total++; if ({o_a, o_prime, o_k, o_px, o_py} !== {va, vp, vk, vx, vy}) begin bad++; $display("FAIL b2b_ops[%0d] got=%h exp=%h", i, {o_a, o_prime, o_k, o_px, o_py}, {va, vp, vk, vx, vy}); end
      total++; if ({cs_early, cs_at} !== {32'd0, 1'b1}) begin bad++; $display("FAIL b2b_cs[%0d] got=%0d/%b exp=0/1", i, cs_early, cs_at); end
      step();
      drive_result(ex, ey, 1 + i % 4, 1'b0, ad, az, gx, gy, xd, aft);
      total++; if ({gx, gy} !== {ex, ey}) begin bad++; $display("FAIL b2b_result[%0d] got=%h exp=%h", i, {gx, gy}, {ex, ey}); end
      total++; if ({ad, az, xd, aft} !== {1'b1, 1'b1, 32'd0, 1'b1}) begin bad++; $display("FAIL b2b_framing[%0d] got=%b%b/%0d/%b exp=11/0/1", i, ad, az, xd, aft); end
      watch(90, cc, dc, kc);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load_and_stream();
    test_restart();
    test_ignored();
    test_reset_mid_shift();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
